// File: rtl/zsel_chunk_decoder.sv
// zsel_chunk_decoder
// Receive side of the 2-bit select-multiplexed chunk link. The high chunk
// (sel=0) carries the inverted upper half of z and the low chunk (sel=1)
// carries the lower half. Each completed pair is decoded back to the 3-bit
// source value. The result goes into a small FIFO with a registered head.
// A one-cycle pulse flags chunk sequencing errors. Saturating counters track
// completed symbols and errors.
module zsel_chunk_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic             in_sel,
  input  logic [1:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_data,
  output logic             out_code_err,
  output logic             proto_err,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HAVE_HI = 1'b1
  } state_t;

  // Decode a 4-bit code into {illegal, a}. The source value is the low three
  // bits plus one. The top bit must match whether that value is in 0..4.
  function automatic logic [3:0] decode_z(input logic [3:0] z);
    logic [2:0] a;
    logic       legal;
    a     = z[2:0] + 3'd1;
    legal = (z[3] == (a <= 3'd4));
    return {~legal, a};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       hi_r;
  logic             in_ready_r;
  logic             accept_s;
  logic             hi_load_s;
  logic             push_s;
  logic             proto_evt_s;
  logic             pop_s;
  logic [3:0]       entry_s;

  logic [3:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W:0]   cnt_r;
  logic [PTR_W:0]   cnt_s;

  logic             out_valid_r;
  logic [2:0]       out_data_r;
  logic             out_code_err_r;
  logic             head_vld_s;
  logic [2:0]       head_data_s;
  logic             head_err_s;
  logic             proto_err_r;

  logic [CNT_W-1:0] sym_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [1:0]       err_inc_s;
  logic [CNT_W:0]   err_sum_s;

  // A chunk is taken only when the FIFO can absorb a possible push.
  assign accept_s     = in_vld & in_ready_r;
  assign pop_s        = out_valid_r & out_ready;
  assign entry_s      = decode_z({hi_r, in_data});
  assign rd_ptr_nxt_s = rd_ptr_r + ONE_PTR;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state. Only accepted chunks move the phase.
  always_comb begin
    state_s = state_r;
    if (accept_s) begin
      case (state_r)
        IDLE:    state_s = in_sel ? IDLE : HAVE_HI;
        HAVE_HI: state_s = in_sel ? IDLE : HAVE_HI;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM actions. A high chunk always (re)loads hi. A low chunk completes a
  // symbol only when a high chunk is pending. Any out-of-phase chunk is a
  // protocol error.
  always_comb begin
    hi_load_s   = 1'b0;
    push_s      = 1'b0;
    proto_evt_s = 1'b0;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          hi_load_s   = ~in_sel;
          proto_evt_s = in_sel;
        end
        HAVE_HI: begin
          hi_load_s   = ~in_sel;
          push_s      = in_sel;
          proto_evt_s = ~in_sel;
        end
        default: begin
          hi_load_s   = 1'b0;
          push_s      = 1'b0;
          proto_evt_s = 1'b0;
        end
      endcase
    end else begin
      hi_load_s   = 1'b0;
      push_s      = 1'b0;
      proto_evt_s = 1'b0;
    end
  end

  // Pending high chunk. It is stored already inverted so it is z[3:2] directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= 2'b00;
    end else if (hi_load_s) begin
      hi_r <= ~in_data;
    end else begin
      hi_r <= hi_r;
    end
  end

  // Occupancy update. The count includes the entry sitting in the head register.
  always_comb begin
    cnt_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_s = cnt_r + ONE_CNT;
      2'b01:   cnt_s = cnt_r - ONE_CNT;
      default: cnt_s = cnt_r;
    endcase
  end

  // Next head contents. An empty FIFO loads a new entry straight into the
  // head, so it is visible one cycle after the low chunk. Otherwise a pop
  // advances to the following stored entry.
  always_comb begin
    head_vld_s  = out_valid_r;
    head_data_s = out_data_r;
    head_err_s  = out_code_err_r;
    if (cnt_r == '0) begin
      if (push_s) begin
        head_vld_s  = 1'b1;
        head_data_s = entry_s[2:0];
        head_err_s  = entry_s[3];
      end else begin
        head_vld_s  = 1'b0;
      end
    end else if (pop_s) begin
      if (cnt_r == ONE_CNT) begin
        if (push_s) begin
          head_vld_s  = 1'b1;
          head_data_s = entry_s[2:0];
          head_err_s  = entry_s[3];
        end else begin
          head_vld_s  = 1'b0;
        end
      end else begin
        head_vld_s  = 1'b1;
        head_data_s = mem_r[rd_ptr_nxt_s][2:0];
        head_err_s  = mem_r[rd_ptr_nxt_s][3];
      end
    end else begin
      head_vld_s  = out_valid_r;
    end
  end

  // FIFO storage, pointers, occupancy and the registered head/ready outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 4'h0;
      end
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      cnt_r          <= '0;
      out_valid_r    <= 1'b0;
      out_data_r     <= 3'd0;
      out_code_err_r <= 1'b0;
      in_ready_r     <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + ONE_PTR;
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      cnt_r          <= cnt_s;
      out_valid_r    <= head_vld_s;
      out_data_r     <= head_data_s;
      out_code_err_r <= head_err_s;
      in_ready_r     <= (cnt_s != FULL_CNT);
    end
  end

  // The error increment is 0, 1 or 2. Saturate at all-ones.
  assign err_inc_s = {1'b0, push_s & entry_s[3]} + {1'b0, proto_evt_s};
  assign err_sum_s = {1'b0, err_cnt_r} + (CNT_W+1)'(err_inc_s);

  // Protocol-error pulse and the saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_r <= 1'b0;
      sym_cnt_r   <= '0;
      err_cnt_r   <= '0;
    end else begin
      proto_err_r <= proto_evt_s;
      if (push_s && (sym_cnt_r != CNT_MAX)) begin
        sym_cnt_r <= sym_cnt_r + CNT_W'(1);
      end else begin
        sym_cnt_r <= sym_cnt_r;
      end
      if (err_sum_s[CNT_W]) begin
        err_cnt_r <= CNT_MAX;
      end else begin
        err_cnt_r <= err_sum_s[CNT_W-1:0];
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_code_err = out_code_err_r;
  assign proto_err    = proto_err_r;
  assign sym_cnt      = sym_cnt_r;
  assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_zsel_chunk_decoder.sv
// Bench for zsel_chunk_decoder. Directed chunk vectors are driven into the
// inputs. The hand-computed {code_err, data} for each completed symbol is
// queued. A monitor compares every popped head against that queue. A second
// instance with CNT_W=2 shares the chunk inputs and exercises saturation.
module tb_zsel_chunk_decoder;

  logic       clk;
  logic       rst_n;
  logic       rst2_n;
  logic       in_vld;
  logic       in_sel;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_code_err;
  logic       proto_err;
  logic [7:0] sym_cnt;
  logic [7:0] err_cnt;

  logic       in_ready2;
  logic       out_valid2;
  logic [2:0] out_data2;
  logic       out_code_err2;
  logic       proto_err2;
  logic [1:0] sym_cnt2;
  logic [1:0] err_cnt2;
  logic       out_ready2;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  zsel_chunk_decoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_sel(in_sel),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_code_err(out_code_err),
    .proto_err(proto_err), .sym_cnt(sym_cnt), .err_cnt(err_cnt)
  );

  zsel_chunk_decoder #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in_vld(in_vld), .in_sel(in_sel),
    .in_data(in_data), .in_ready(in_ready2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .out_code_err(out_code_err2),
    .proto_err(proto_err2), .sym_cnt(sym_cnt2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every head the consumer takes must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got data=%0d err=%0d expected no entry",
                 out_data, out_code_err);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if ({out_code_err, out_data} != e) begin
          fails++;
          $display("FAIL pop_data: got err=%0d data=%0d expected err=%0d data=%0d",
                   out_code_err, out_data, e[3], e[2:0]);
        end
      end
    end
  end

  // Drive one chunk and hold it until it is accepted, or until the bound expires.
  task automatic send(input logic sel, input logic [1:0] data);
    int n;
    in_vld  = 1'b1;
    in_sel  = sel;
    in_data = data;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  // Send a full symbol and queue its hand-computed result.
  task automatic send_sym(input logic [1:0] hi_c, input logic [1:0] lo_c,
                          input logic err, input logic [2:0] a);
    send(1'b0, hi_c);
    exp_q.push_back({err, a});
    send(1'b1, lo_c);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    rst2_n     = 1'b0;
    in_vld     = 1'b0;
    in_sel     = 1'b0;
    in_data    = 2'b00;
    out_ready  = 1'b1;
    out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sym_cnt", sym_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // z=0100 -> a=5, legal
    send(1'b0, 2'b10);
    exp_q.push_back({1'b0, 3'd5});
    send(1'b1, 2'b00);
    check("first_out_valid", out_valid, 1);
    check("first_out_data", out_data, 5);
    check("first_code_err", out_code_err, 0);
    check("first_sym_cnt", sym_cnt, 1);

    // z=1111 -> a=0 legal; z=0000 -> a=1 illegal
    send_sym(2'b00, 2'b11, 1'b0, 3'd0);
    send_sym(2'b11, 2'b00, 1'b1, 3'd1);
    check("illegal_err_cnt", err_cnt, 1);

    // Lone low chunk in IDLE
    send(1'b1, 2'b01);
    check("lone_lo_proto", proto_err, 1);
    check("lone_lo_err_cnt", err_cnt, 2);
    check("lone_lo_sym_cnt", sym_cnt, 3);
    @(posedge clk);
    #1;
    check("proto_pulse_width", proto_err, 0);

    // Double high chunk: the second hi wins, z=0101 -> a=6
    send(1'b0, 2'b01);
    send(1'b0, 2'b10);
    check("double_hi_proto", proto_err, 1);
    check("double_hi_err_cnt", err_cnt, 3);
    exp_q.push_back({1'b0, 3'd6});
    send(1'b1, 2'b01);
    check("double_hi_sym_cnt", sym_cnt, 4);
    wait_drain();

    // Fill the FIFO: z=8,9,10,11 -> a=1..4; then z=6 -> a=7 stalls
    out_ready = 1'b0;
    send_sym(2'b01, 2'b00, 1'b0, 3'd1);
    send_sym(2'b01, 2'b01, 1'b0, 3'd2);
    send_sym(2'b01, 2'b10, 1'b0, 3'd3);
    send_sym(2'b01, 2'b11, 1'b0, 3'd4);
    check("full_in_ready", in_ready, 0);
    check("full_sym_cnt", sym_cnt, 8);
    fork
      send_sym(2'b10, 2'b10, 1'b0, 3'd7);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_sym_cnt", sym_cnt, 8);
        check("stall_head", out_data, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("after_pop_in_ready", in_ready, 1);
      end
    join
    check("stalled_sym_cnt", sym_cnt, 9);
    check("refull_in_ready", in_ready, 0);
    out_ready = 1'b1;
    wait_drain();

    // Async reset mid-symbol with two entries queued
    out_ready = 1'b0;
    send_sym(2'b10, 2'b00, 1'b0, 3'd5);
    send_sym(2'b00, 2'b11, 1'b0, 3'd0);
    send(1'b0, 2'b10);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sym_cnt", sym_cnt, 0);
    check("async_rst_err_cnt", err_cnt, 0);
    check("async_rst_proto", proto_err, 0);
    check("async_rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1'b1, 2'b01);
    check("post_rst_proto", proto_err, 1);
    @(posedge clk);
    #1;
    check("post_rst_no_push", out_valid, 0);
    check("post_rst_sym_cnt", sym_cnt, 0);
    check("post_rst_err_cnt", err_cnt, 1);

    // Saturation on the narrow instance: five illegal z=0 symbols
    @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      send_sym(2'b11, 2'b00, 1'b1, 3'd1);
    end
    check("sat3_sym_cnt2", sym_cnt2, 3);
    check("sat3_err_cnt2", err_cnt2, 3);
    for (int i = 0; i < 2; i++) begin
      send_sym(2'b11, 2'b00, 1'b1, 3'd1);
    end
    check("sat5_sym_cnt2", sym_cnt2, 3);
    check("sat5_err_cnt2", err_cnt2, 3);
    check("wide_sym_cnt", sym_cnt, 5);
    check("wide_err_cnt", err_cnt, 6);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
